// File: rtl/mnist_loader_pkg.sv
// Shared constants and FSM state type for the MNIST UART image loader.
// LOADER_CHECKSUM_EN adds the CHECK state used for the trailing XOR byte.
package mnist_loader_pkg;
    localparam int         IMG_BYTES = 98;
    localparam logic [7:0] HDR_BYTE  = 8'hA5;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_COLLECT = 2'd1,
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK   = 2'd2,
`endif
        ST_STREAM  = 2'd3
    } loader_state_t;
endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop synchroniser, start-bit glitch rejection,
// mid-bit sampling LSB first; valid/frame_err pulse the cycle after the stop sample.
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);
    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    // A line that is high again at half-bit was only a glitch.
                    if (cnt == HALF_END) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_END) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == BIT_END) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_sync) begin
                            data  <= shreg;
                            valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/mnist_uart_loader.sv
// Receives a 0xA5-headed 98-byte binarised image over UART and streams it to the core.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before streaming.
module mnist_uart_loader
    import mnist_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT_CLKS = 120000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] pix_data,
    output logic       pix_valid,
    output logic       pix_last,
    input  logic       pix_ready,
    output logic       frame_done,
    output logic       busy,
    output logic       err
);
    localparam int            TW       = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT_CLKS - 1);
    localparam logic [6:0]    LAST_IDX = 7'(IMG_BYTES - 1);

    loader_state_t state;
    logic [6:0]    idx;
    logic [6:0]    idx_inc;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    img_buf [IMG_BYTES];
    logic [7:0]    rx_data;
    logic          rx_valid, rx_ferr;
    logic          in_frame;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (uart_rx),
        .data      (rx_data),
        .valid     (rx_valid),
        .frame_err (rx_ferr)
    );

    assign idx_inc = idx + 7'd1;
    assign busy    = (state != ST_HUNT);
`ifdef LOADER_CHECKSUM_EN
    assign in_frame = (state == ST_COLLECT) || (state == ST_CHECK);
`else
    assign in_frame = (state == ST_COLLECT);
`endif

    always_ff @(posedge clk) begin
        if (state == ST_COLLECT && rx_valid) img_buf[idx] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_HUNT;
            idx        <= '0;
            tmo_cnt    <= '0;
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            pix_last   <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (rx_ferr) err <= 1'b1;
            // Inter-byte watchdog; a stalled frame is abandoned without streaming.
            if (in_frame) begin
                if (rx_valid) begin
                    tmo_cnt <= '0;
                end else if (tmo_cnt == TMO_END) begin
                    tmo_cnt <= '0;
                    state   <= ST_HUNT;
                    err     <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end
            case (state)
                ST_HUNT: begin
                    if (rx_valid && rx_data == HDR_BYTE) begin
                        state   <= ST_COLLECT;
                        idx     <= '0;
                        tmo_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum    <= '0;
`endif
                    end
                end
                ST_COLLECT: begin
                    if (rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ rx_data;
`endif
                        if (idx == LAST_IDX) begin
                            idx <= '0;
`ifdef LOADER_CHECKSUM_EN
                            state <= ST_CHECK;
`else
                            state <= ST_STREAM;
`endif
                        end else begin
                            idx <= idx_inc;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (rx_valid) begin
                        if (rx_data == csum) begin
                            state <= ST_STREAM;
                        end else begin
                            state <= ST_HUNT;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                ST_STREAM: begin
                    // First cycle in STREAM loads byte 0; each handshake preloads the next.
                    if (!pix_valid) begin
                        pix_valid <= 1'b1;
                        pix_data  <= img_buf[idx];
                        pix_last  <= (idx == LAST_IDX);
                    end else if (pix_ready) begin
                        if (pix_last) begin
                            pix_valid  <= 1'b0;
                            pix_last   <= 1'b0;
                            frame_done <= 1'b1;
                            idx        <= '0;
                            state      <= ST_HUNT;
                        end else begin
                            idx      <= idx_inc;
                            pix_data <= img_buf[idx_inc];
                            pix_last <= (idx_inc == LAST_IDX);
                        end
                    end
                end
                default: state <= ST_HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_mnist_uart_loader.sv
// Bench for mnist_uart_loader: UART frame driver, expected-byte queue model and per-cycle stream checker.
`timescale 1ns/1ps
module tb_mnist_uart_loader;
    localparam int CPB = 4;
    localparam int TMO = 300;
    localparam int NB  = 98;

    logic       clk = 1'b0;
    logic       rst_n, uart_rx, pix_ready;
    logic [7:0] pix_data;
    logic       pix_valid, pix_last, frame_done, busy, err;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] frame_data [NB];
    logic [7:0] frame_xor;
    int         ready_mode = 0;
    int         beat = 0;
    int         valid_cycles = 0;
    int         frames_done = 0;
    logic       done_due = 1'b0;
    logic       stall_hold = 1'b0;
    logic [7:0] held_data, exp_b, first_seen, last_seen;
    logic       held_last;
`ifdef LOADER_CHECKSUM_EN
    logic       bad_csum = 1'b0;
`endif

    mnist_uart_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_last   (pix_last),
        .pix_ready  (pix_ready),
        .frame_done (frame_done),
        .busy       (busy),
        .err        (err)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // driver tasks
    task automatic uart_bit(input logic v);
        uart_rx = v;
        step(CPB);
    endtask

    task automatic uart_byte(input logic [7:0] b, input logic stop_ok);
        uart_bit(1'b0);
        for (int i = 0; i < 8; i++) uart_bit(b[i]);
        uart_bit(stop_ok);
        uart_rx = 1'b1;
        step(stop_ok ? 1 : 2 * CPB);
    endtask

    task automatic uart_glitch();
        uart_rx = 1'b0;
        step(1);
        uart_rx = 1'b1;
        step(3 * CPB);
    endtask

    task automatic send_frame(input int glitch_at);
        logic [7:0] x;
        x = 8'h00;
`ifdef LOADER_CHECKSUM_EN
        if (!bad_csum) for (int i = 0; i < NB; i++) exp_q.push_back(frame_data[i]);
`else
        for (int i = 0; i < NB; i++) exp_q.push_back(frame_data[i]);
`endif
        uart_byte(8'hA5, 1'b1);
        for (int i = 0; i < NB; i++) begin
            if (i == glitch_at) uart_glitch();
            uart_byte(frame_data[i], 1'b1);
            x = x ^ frame_data[i];
        end
        frame_xor = x;
`ifdef LOADER_CHECKSUM_EN
        uart_byte(bad_csum ? (x ^ 8'h01) : x, 1'b1);
`endif
    endtask

    task automatic random_frame();
        for (int i = 0; i < NB; i++) frame_data[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy || pix_valid) && k < 5000) begin
            step(1);
            k++;
        end
        check("idle_reached", 32'(k < 5000), 32'd1);
        step(3);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = 1'($urandom_range(0, 1));
                default: pix_ready = ~pix_ready;
            endcase
        end
    end

    // scoreboard: every active cycle the stream must match the expected queue
    always @(negedge clk) begin
        if (!rst_n) begin
            beat = 0;
            done_due = 1'b0;
            stall_hold = 1'b0;
            valid_cycles = 0;
        end else begin
            check("frame_done", 32'(frame_done), 32'(done_due));
            if (frame_done) begin
                frames_done++;
                check("valid_on_done", 32'(pix_valid), 32'd0);
            end
            done_due = 1'b0;
            if (pix_valid) begin
                valid_cycles++;
                if (stall_hold) begin
                    check("stall_data", 32'(pix_data), 32'(held_data));
                    check("stall_last", 32'(pix_last), 32'(held_last));
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(pix_valid), 32'd0);
                    stall_hold = 1'b0;
                end else if (pix_ready) begin
                    exp_b = exp_q.pop_front();
                    check("pix_data", 32'(pix_data), 32'(exp_b));
                    check("pix_last", 32'(pix_last), 32'(beat == NB - 1));
                    if (beat == 0) first_seen = pix_data;
                    last_seen = pix_data;
                    beat++;
                    stall_hold = 1'b0;
                    if (beat == NB) begin
                        beat = 0;
                        done_due = 1'b1;
                        if (ready_mode == 0) check("beat_cycles", 32'(valid_cycles), 32'(NB));
                        valid_cycles = 0;
                    end
                end else begin
                    stall_hold = 1'b1;
                    held_data = pix_data;
                    held_last = pix_last;
                end
            end else begin
                if (stall_hold) check("valid_dropped", 32'(pix_valid), 32'd1);
                stall_hold = 1'b0;
            end
        end
    end

    initial begin
        int k;
        rst_n = 1'b0;
        uart_rx = 1'b1;
        step(4);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_last", 32'(pix_last), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        step(4);

        // nominal ramp frame, ready held high
        for (int i = 0; i < NB; i++) frame_data[i] = 8'(i);
        send_frame(-1);
        wait_idle();
        check("nominal_err", 32'(err), 32'd0);
        check("nominal_first", 32'(first_seen), 32'h00);
        check("nominal_last", 32'(last_seen), 32'h61);
        check("nominal_frames", 32'(frames_done), 32'd1);

        // toggling ready; a header byte arriving mid-stream is dropped
        ready_mode = 2;
        random_frame();
        send_frame(-1);
        k = 0;
        while (!pix_valid && k < 200) begin step(1); k++; end
        check("stream_started", 32'(pix_valid), 32'd1);
        uart_byte(8'hA5, 1'b1);
        wait_idle();
        check("bp_busy", 32'(busy), 32'd0);
        check("bp_frames", 32'(frames_done), 32'd2);

        // random ready, 0xA5 as data, glitch inside the frame
        ready_mode = 1;
        random_frame();
        frame_data[5] = 8'hA5;
        frame_data[50] = 8'hA5;
        frame_data[97] = 8'h3C;
        send_frame(97);
        wait_idle();
        check("glitch_frames", 32'(frames_done), 32'd3);
        check("glitch_err", 32'(err), 32'd0);

        // all-0xFF frame: XOR of an even count of 0xFF is zero
        ready_mode = 0;
        for (int i = 0; i < NB; i++) frame_data[i] = 8'hFF;
        send_frame(-1);
        check("ff_xor", 32'(frame_xor), 32'h00);
        wait_idle();
        check("ff_frames", 32'(frames_done), 32'd4);
`ifdef LOADER_CHECKSUM_EN
        bad_csum = 1'b1;
        send_frame(-1);
        step(20);
        check("badsum_err", 32'(err), 32'd1);
        check("badsum_busy", 32'(busy), 32'd0);
        bad_csum = 1'b0;
`endif

        // resync then inter-byte timeout
        pulse_reset();
        uart_byte(8'h12, 1'b1);
        uart_byte(8'h34, 1'b1);
        step(4);
        check("resync_busy", 32'(busy), 32'd0);
        uart_byte(8'hA5, 1'b1);
        step(4);
        check("hdr_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 10; i++) uart_byte(8'($urandom_range(0, 255)), 1'b1);
        step(TMO - 20);
        check("pre_tmo_busy", 32'(busy), 32'd1);
        check("pre_tmo_err", 32'(err), 32'd0);
        step(28);
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_err", 32'(err), 32'd1);

        // framing error
        pulse_reset();
        check("post_rst_err", 32'(err), 32'd0);
        uart_byte(8'h33, 1'b0);
        check("ferr_err", 32'(err), 32'd1);
        check("ferr_busy", 32'(busy), 32'd0);

        // reset in the middle of a stream
        pulse_reset();
        ready_mode = 1;
        random_frame();
        send_frame(-1);
        k = 0;
        while (beat < 40 && k < 2000) begin step(1); k++; end
        check("reached_beat40", 32'(beat >= 40), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        step(1);
        check("midrst_valid", 32'(pix_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        step(3);
        rst_n = 1'b1;
        step(2);

        // fresh frame after reset streams from byte 0
        ready_mode = 0;
        random_frame();
        send_frame(-1);
        wait_idle();
        check("fresh_first", 32'(first_seen), 32'(frame_data[0]));
        check("fresh_err", 32'(err), 32'd0);
        check("total_frames", 32'(frames_done), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
